// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral.
//   - Word addresses of the register map (compared against the zero-extended bus address)
//   - irq_type_e: per-pin interrupt type (edge or level)
//   - Bit positions inside the CTRL register
package gpio_pkg;

    localparam logic [31:0] ADDR_DIR      = 32'd0;
    localparam logic [31:0] ADDR_OUT      = 32'd1;
    localparam logic [31:0] ADDR_IN       = 32'd2;
    localparam logic [31:0] ADDR_OUT_SET  = 32'd3;
    localparam logic [31:0] ADDR_OUT_CLR  = 32'd4;
    localparam logic [31:0] ADDR_OUT_TGL  = 32'd5;
    localparam logic [31:0] ADDR_IRQ_EN   = 32'd6;
    localparam logic [31:0] ADDR_IRQ_TYPE = 32'd7;
    localparam logic [31:0] ADDR_IRQ_POL  = 32'd8;
    localparam logic [31:0] ADDR_IRQ_BOTH = 32'd9;
    localparam logic [31:0] ADDR_PEND     = 32'd10;
    localparam logic [31:0] ADDR_CTRL     = 32'd11;

    typedef enum logic {
        IRQ_EDGE  = 1'b0,
        IRQ_LEVEL = 1'b1
    } irq_type_e;

    localparam int CTRL_SRST_BIT = 0;
    localparam int CTRL_GIE_BIT  = 1;

endpackage

// File: rtl/gpio_ctrl_v2_if.sv
// Avalon-MM slave bus bundle for the GPIO peripheral.
//   address    word address (ADDR_W bits)
//   write      write strobe, qualified by chipselect
//   writedata  32-bit write data
//   read       read strobe, qualified by chipselect
//   chipselect slave select
//   readdata   registered read data, valid one cycle after a read
interface gpio_ctrl_v2_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic              chipselect;
    logic [31:0]       readdata;

    modport master (
        output address, write, writedata, read, chipselect,
        input  readdata
    );

    modport slave (
        input  address, write, writedata, read, chipselect,
        output readdata
    );
endinterface

// File: rtl/gpio_ctrl_v2_in_filter.sv
// Single-pin input conditioning: 2-flop synchroniser followed by a
// stability filter.
//   clk_i     clock
//   resetn_i  synchronous active-low reset
//   pad_i     asynchronous pad input
//   filt_o    filtered, synchronised value
// The filtered bit follows the synchronised bit once the latter has differed
// from it for FILTER_DEPTH consecutive cycles; FILTER_DEPTH = 0 bypasses
// the filter.
module gpio_in_filter #(
    parameter int FILTER_DEPTH = 2
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic pad_i,
    output logic filt_o
);
    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pad_i;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        if (FILTER_DEPTH == 0) begin : g_bypass
            assign filt_o = sync2_reg;
        end else begin : g_filter
            localparam int CNT_W = $clog2(FILTER_DEPTH + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_DEPTH - 1);

            logic [CNT_W-1:0] cnt_reg;
            logic             filt_reg;

            // A pin has only two values, so "differs from the filtered bit"
            // is the same as "equals the previous differing sample"; a
            // sample that matches the filtered bit restarts the count.
            always_ff @(posedge clk_i) begin
                if (!resetn_i) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (sync2_reg == filt_reg) begin
                    cnt_reg  <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg  <= '0;
                    filt_reg <= sync2_reg;
                end else begin
                    cnt_reg  <= cnt_reg + 1'b1;
                end
            end

            assign filt_o = filt_reg;
        end
    endgenerate
endmodule

// File: rtl/gpio_ctrl_v2.sv
// Parametrised GPIO peripheral on an Avalon-MM slave bus.
//   clk_i     clock
//   resetn_i  synchronous active-low reset
//   bus       Avalon-MM slave (address/write/writedata/read/chipselect/readdata)
//   gpio_i    asynchronous pad inputs
//   gpio_o    pad output values (OUT register)
//   gpio_oen  pad output enables (DIR register, 1 = drive)
//   irq_o     combined interrupt: |(PEND & IRQ_EN) & GIE
// Holds the register file, atomic set/clear/toggle, edge/level detection,
// the sticky W1C pending register and the registered read path.
module gpio_ctrl_v2
    import gpio_pkg::*;
#(
    parameter int NUM_PINS     = 32,
    parameter int FILTER_DEPTH = 2,
    parameter int ADDR_W       = 4
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    gpio_ctrl_v2_if.slave       bus,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oen,
    output logic                irq_o
);
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         addr_idx;
    logic [NUM_PINS-1:0] wdata;
    logic                unused_wdata;
    logic                wr_en;
    logic                rd_en;
    logic                srst_req;
    logic                rst_all;
    logic                filt_resetn;

    logic [NUM_PINS-1:0] dir_reg, out_reg, out_next;
    logic [NUM_PINS-1:0] irq_en_reg, irq_type_reg, irq_pol_reg, irq_both_reg;
    logic [NUM_PINS-1:0] pend_reg, pend_next;
    logic                gie_reg;
    logic [NUM_PINS-1:0] filt, filt_d_reg;
    logic [NUM_PINS-1:0] cond;
    logic [31:0]         readdata_reg, rd_val;

    assign addr         = bus.address;
    assign addr_idx     = 32'(addr);
    assign wdata        = bus.writedata[NUM_PINS-1:0];
    assign unused_wdata = ^bus.writedata;
    assign wr_en        = bus.chipselect & bus.write;
    // A simultaneous write takes priority; the read is dropped.
    assign rd_en        = bus.chipselect & bus.read & ~wr_en;

    // The soft reset acts on the same edge as its write, so the very next
    // cycle looks exactly like the cycle after a hardware reset.
    assign srst_req    = wr_en && (addr_idx == ADDR_CTRL) && bus.writedata[CTRL_SRST_BIT];
    assign rst_all     = !resetn_i || srst_req;
    assign filt_resetn = ~rst_all;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic rise, fall, edge_hit, level_hit;

            gpio_in_filter #(
                .FILTER_DEPTH(FILTER_DEPTH)
            ) u_filter (
                .clk_i    (clk_i),
                .resetn_i (filt_resetn),
                .pad_i    (gpio_i[gi]),
                .filt_o   (filt[gi])
            );

            assign rise      = filt[gi] & ~filt_d_reg[gi];
            assign fall      = ~filt[gi] & filt_d_reg[gi];
            assign edge_hit  = irq_both_reg[gi] ? (rise | fall)
                                                : (irq_pol_reg[gi] ? fall : rise);
            // POL=1 selects active-low.
            assign level_hit = filt[gi] ^ irq_pol_reg[gi];
            assign cond[gi]  = ~dir_reg[gi] & irq_en_reg[gi] &
                               ((irq_type_reg[gi] == IRQ_LEVEL) ? level_hit : edge_hit);
        end
    endgenerate

    always_comb begin
        out_next = out_reg;
        if (wr_en) begin
            case (addr_idx)
                ADDR_OUT:     out_next = wdata;
                ADDR_OUT_SET: out_next = out_reg | wdata;
                ADDR_OUT_CLR: out_next = out_reg & ~wdata;
                ADDR_OUT_TGL: out_next = out_reg ^ wdata;
                default:      out_next = out_reg;
            endcase
        end
    end

    // New conditions are OR-ed in after the W1C mask, so a set wins.
    always_comb begin
        pend_next = pend_reg;
        if (wr_en && (addr_idx == ADDR_PEND)) begin
            pend_next = pend_reg & ~wdata;
        end
        pend_next = pend_next | cond;
    end

    always_comb begin
        rd_val = '0;
        case (addr_idx)
            ADDR_DIR:      rd_val = 32'(dir_reg);
            ADDR_OUT:      rd_val = 32'(out_reg);
            ADDR_IN:       rd_val = 32'(filt);
            ADDR_IRQ_EN:   rd_val = 32'(irq_en_reg);
            ADDR_IRQ_TYPE: rd_val = 32'(irq_type_reg);
            ADDR_IRQ_POL:  rd_val = 32'(irq_pol_reg);
            ADDR_IRQ_BOTH: rd_val = 32'(irq_both_reg);
            ADDR_PEND:     rd_val = 32'(pend_reg);
            ADDR_CTRL:     rd_val[CTRL_GIE_BIT] = gie_reg;
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_all) begin
            dir_reg      <= '0;
            out_reg      <= '0;
            irq_en_reg   <= '0;
            irq_type_reg <= '0;
            irq_pol_reg  <= '0;
            irq_both_reg <= '0;
            pend_reg     <= '0;
            gie_reg      <= 1'b0;
            filt_d_reg   <= '0;
            readdata_reg <= '0;
        end else begin
            if (wr_en) begin
                case (addr_idx)
                    ADDR_DIR:      dir_reg      <= wdata;
                    ADDR_IRQ_EN:   irq_en_reg   <= wdata;
                    ADDR_IRQ_TYPE: irq_type_reg <= wdata;
                    ADDR_IRQ_POL:  irq_pol_reg  <= wdata;
                    ADDR_IRQ_BOTH: irq_both_reg <= wdata;
                    ADDR_CTRL:     gie_reg      <= bus.writedata[CTRL_GIE_BIT];
                    default:       ;
                endcase
            end
            out_reg    <= out_next;
            pend_reg   <= pend_next;
            filt_d_reg <= filt;
            if (rd_en) begin
                readdata_reg <= rd_val;
            end
        end
    end

    assign bus.readdata = readdata_reg;
    assign gpio_o       = out_reg;
    assign gpio_oen     = dir_reg;
    assign irq_o        = (|(pend_reg & irq_en_reg)) & gie_reg;
endmodule

// File: tb/tb_gpio_ctrl_v2.sv
module tb_gpio_ctrl_v2;
    localparam int NUM_PINS     = 8;
    localparam int FILTER_DEPTH = 2;
    localparam int ADDR_W       = 4;

    logic                clk_i = 1'b0;
    logic                resetn_i;
    logic [NUM_PINS-1:0] gpio_i;
    logic [NUM_PINS-1:0] gpio_o;
    logic [NUM_PINS-1:0] gpio_oen;
    logic                irq_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    gpio_ctrl_v2_if #(.ADDR_W(ADDR_W)) bus_if ();

    gpio_ctrl_v2 #(
        .NUM_PINS     (NUM_PINS),
        .FILTER_DEPTH (FILTER_DEPTH),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .bus      (bus_if),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oen (gpio_oen),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = d;
        @(posedge clk_i);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = a;
        @(posedge clk_i);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        d = bus_if.readdata;
        $display("read  addr=%0d data=0x%08h", a, d);
    endtask

    initial begin
        resetn_i          = 1'b0;
        gpio_i            = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.read       = 1'b0;
        bus_if.address    = '0;
        bus_if.writedata  = '0;
        idle(3);

        // 1. Reset state
        check("rst_readdata", bus_if.readdata, 32'h0);
        check("rst_oen", 32'(gpio_oen), 32'h0);
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        resetn_i = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(ADDR_W'(a), rd);
            check($sformatf("rst_rd_a%0d", a), rd, 32'h0);
        end

        // 2. Direction and atomic output operations
        bus_write(4'd0, 32'h0000_00FF);
        check("dir_oen", 32'(gpio_oen), 32'h0000_00FF);
        bus_write(4'd1, 32'h0000_000F);
        check("out_wr", 32'(gpio_o), 32'h0000_000F);
        bus_write(4'd3, 32'h0000_0030);
        check("out_set", 32'(gpio_o), 32'h0000_003F);
        bus_write(4'd4, 32'h0000_0001);
        check("out_clr", 32'(gpio_o), 32'h0000_003E);
        bus_write(4'd5, 32'h0000_0081);
        check("out_tgl", 32'(gpio_o), 32'h0000_00BF);
        bus_read(4'd1, rd);
        check("out_rd", rd, 32'h0000_00BF);
        bus_read(4'd3, rd);
        check("set_rd_zero", rd, 32'h0);
        bus_write(4'd0, 32'h0);
        check("dir_in", 32'(gpio_oen), 32'h0);

        // 3. Glitch filter: one-cycle pulse is rejected
        gpio_i = 8'h08;
        idle(1);
        gpio_i = 8'h00;
        idle(6);
        bus_read(4'd2, rd);
        check("in_pulse", rd, 32'h0);

        // Held high: IN[3] updates exactly 4 cycles after the pad rise
        gpio_i = 8'h08;
        idle(3);
        bus_read(4'd2, rd);
        check("in_lat_minus1", rd, 32'h0);
        bus_read(4'd2, rd);
        check("in_lat_exact", rd, 32'h0000_0008);
        idle(1);
        gpio_i = 8'h00;
        idle(6);
        bus_read(4'd2, rd);
        check("in_fall", rd, 32'h0);

        // 4. Rising-edge interrupt on pin 3
        bus_write(4'd6, 32'h0000_0008);
        bus_write(4'd11, 32'h0000_0002);
        bus_read(4'd11, rd);
        check("ctrl_gie_rd", rd, 32'h0000_0002);
        check("irq_idle", 32'(irq_o), 32'h0);
        gpio_i = 8'h08;
        idle(6);
        bus_read(4'd10, rd);
        check("pend_rise", rd, 32'h0000_0008);
        check("irq_rise", 32'(irq_o), 32'h1);
        bus_write(4'd10, 32'h0000_0008);
        check("irq_w1c", 32'(irq_o), 32'h0);
        gpio_i = 8'h00;
        idle(8);
        bus_read(4'd10, rd);
        check("pend_fall_none", rd, 32'h0);
        check("irq_fall_none", 32'(irq_o), 32'h0);

        // Both-edge mode: fall now pends too
        bus_write(4'd9, 32'h0000_0008);
        gpio_i = 8'h08;
        idle(8);
        bus_write(4'd10, 32'h0000_0008);
        gpio_i = 8'h00;
        idle(8);
        bus_read(4'd10, rd);
        check("pend_both_fall", rd, 32'h0000_0008);
        // Clearing IRQ_EN masks irq_o but keeps PEND
        bus_write(4'd6, 32'h0);
        check("irq_masked", 32'(irq_o), 32'h0);
        bus_read(4'd10, rd);
        check("pend_kept", rd, 32'h0000_0008);
        bus_write(4'd10, 32'h0000_0008);
        bus_write(4'd9, 32'h0);

        // 5. Level-low interrupt on pin 5 (pad already low)
        bus_write(4'd7, 32'h0000_0020);
        bus_write(4'd8, 32'h0000_0020);
        bus_write(4'd6, 32'h0000_0020);
        idle(2);
        bus_read(4'd10, rd);
        check("pend_level", rd, 32'h0000_0020);
        check("irq_level", 32'(irq_o), 32'h1);
        bus_write(4'd10, 32'h0000_0020);
        bus_read(4'd10, rd);
        check("pend_set_wins", rd, 32'h0000_0020);
        gpio_i = 8'h20;
        idle(6);
        bus_write(4'd10, 32'h0000_0020);
        bus_read(4'd10, rd);
        check("pend_released", rd, 32'h0);
        check("irq_released", 32'(irq_o), 32'h0);

        // 6. Upper bits ignored, write+read collision, soft reset
        bus_write(4'd0, 32'hFFFF_FFFF);
        bus_read(4'd0, rd);
        check("dir_masked", rd, 32'h0000_00FF);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = 4'd1;
        bus_if.writedata  = 32'h0000_0055;
        idle(1);
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.read       = 1'b0;
        $display("write+read addr=1 data=0x00000055");
        check("wr_rd_hold", bus_if.readdata, 32'h0000_00FF);
        check("wr_rd_out", 32'(gpio_o), 32'h0000_0055);
        bus_write(4'd11, 32'h0000_0003);
        check("srst_oen", 32'(gpio_oen), 32'h0);
        check("srst_gpio_o", 32'(gpio_o), 32'h0);
        bus_read(4'd0, rd);
        check("srst_dir", rd, 32'h0);
        bus_read(4'd11, rd);
        check("srst_ctrl", rd, 32'h0);
        bus_read(4'd7, rd);
        check("srst_type", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
